mcs8_fetch_unit: RTL
====================

// Module: mcs8_fetch_unit
// PURPOSE
//  Parametrised front end for the MCS8 pipeline. Holds the PC stack, fetches bytes from the
//  instruction ROM and buffers them in a byte FIFO. Assembles 1/2/3-byte instructions and
//  hands them to decode over a valid/ready handshake. Accepts jump/call/return redirects
//  with a full front-end flush. Replaces the fixed F1->F2->F3 shift chain.
// PARAMETERS
//  ADDR_W      14  ROM byte address width
//  STACK_DEPTH 8   PC stack entries, power of 2; STACK_DEPTH>=2
//  FIFO_DEPTH  4   byte FIFO entries, power of 2, >=4
// PORTS
//  CLK_I       in   1       clock, all logic on rising edge
//  RST_I       in   1       synchronous reset, active-high
//  I_DAT_I     in   8       ROM data; valid 1 cycle after I_ADDR_O was presented with I_REQ_O=1
//  I_ADDR_O    out  ADDR_W  ROM address = top-of-stack PC
//  I_REQ_O     out  1       fetch issued this cycle
//  INS_VALID_O out  1       instruction bundle valid
//  INS_READY_I in   1       decode accepts bundle
//  INS_OP_O    out  8       opcode byte
//  INS_B2_O    out  8       2nd byte (0 if LEN<2)
//  INS_B3_O    out  8       3rd byte (0 if LEN<3)
//  INS_LEN_O   out  2       1,2,3
//  INS_PC_O    out  ADDR_W  address of opcode byte
//  BR_VALID_I  in   1       redirect request, single-cycle
//  BR_TYPE_I   in   2       00 jump, 01 call, 10 return, 11 reserved (ignored, no flush)
//  BR_ADDR_I   in   ADDR_W  target (jump/call)
//  BR_RET_I    in   ADDR_W  return address (call)
//  STK_ERR_O   out  1       1-cycle pulse: call on full stack or return on depth-1 stack
// BEHAVIOUR
//  Reset: all stack entries 0, index 0, FIFO/assembler empty, epoch 0; I_REQ_O=0,
//   INS_VALID_O=0, INS_* = 0, STK_ERR_O=0. First I_REQ_O=1 the cycle after RST_I deasserts.
//  Fetch: I_REQ_O=1 when (FIFO count + in-flight reads) < FIFO_DEPTH; each issued fetch
//   increments top-of-stack PC by 1 (wraps mod 2^ADDR_W). Returned byte written to FIFO
//   next cycle tagged with issue-time epoch; byte discarded if epoch differs from current.
//  Length decode on opcode b: LEN=2 if b[7:6]=00 & b[2]=1 & b[0]=0; LEN=3 if b[7:6]=01 &
//   b[0]=0; else LEN=1.
//  Assembler: pops opcode, then LEN-1 further bytes as available; INS_VALID_O rises the
//   cycle after last byte popped; held stable (all INS_*) until INS_VALID_O&INS_READY_I.
//   Next bundle may be valid the cycle after acceptance if bytes buffered (1 instr/cycle max).
//   Min latency ROM byte in -> INS_VALID_O for 1-byte instr: 2 cycles.
//  INS_PC_O tracks opcode address: redirect target, then +LEN per accepted bundle.
//  Redirect (BR_VALID_I, type!=11): at edge, epoch toggles, FIFO+assembler cleared,
//   INS_VALID_O=0 next cycle; in-flight byte dropped.
//   jump:   stack[idx] <= BR_ADDR_I.
//   call:   stack[idx] <= BR_RET_I; idx <= idx+1; stack[idx+1] <= BR_ADDR_I.
//   return: idx <= idx-1; fetch resumes at stack[idx-1] unchanged.
//   Index wraps mod STACK_DEPTH; call with idx=STACK_DEPTH-1 or return with idx=0 still
//   performed (wrap) and pulses STK_ERR_O the following cycle.
//   First I_REQ_O to new address the cycle after redirect.
//  Simultaneous: handshake and redirect same cycle -> bundle counts as accepted, then flush.
//   Redirect has priority over fetch increment that cycle (no PC+1 applied).
//  RST_I mid-operation overrides everything, including pending redirect and held bundle.
// TESTING
//  T1 reset: ROM 0x00..=opcodes; RST_I 2 cycles -> I_ADDR_O=0, INS_VALID_O=0, first REQ next.
//  T2 stream: ROM[0..5]=C0,06,55,44,34,12 (READY=1) -> bundles {C0,L1,PC0},{06 55,L2,PC1},
//   {44 34 12,L3,PC3}.
//  T3 backpressure: READY=0 for 20 cycles -> bundle held stable, I_REQ_O drops once FIFO
//   full, no byte lost; READY=1 -> remaining bundles in order.
//  T4 jump: BR jump 0x1234 mid-stream -> next bundle INS_PC_O=0x1234, no stale bytes.
//  T5 call/return: call 0x0200 ret 0x0010 then return -> fetch resumes at 0x0010; 8 nested
//   calls (DEPTH 8) -> STK_ERR_O pulse on 8th, idx wraps to 0.
//  T6 collision: BR_VALID_I with VALID&READY same cycle -> bundle accepted once, none after
//   until target bytes arrive; RST_I during held bundle -> VALID=0 next cycle.

Source files
------------

// File: rtl/mcs8_fetch_unit.sv
// mcs8_fetch_unit: MCS8 front end - PC stack, ROM fetch, byte FIFO and 1/2/3-byte instruction assembler.
module mcs8_fetch_unit #(
    parameter int ADDR_W      = 14,
    parameter int STACK_DEPTH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [7:0]        I_DAT_I,
    output logic [ADDR_W-1:0] I_ADDR_O,
    output logic              I_REQ_O,
    output logic              INS_VALID_O,
    input  logic              INS_READY_I,
    output logic [7:0]        INS_OP_O,
    output logic [7:0]        INS_B2_O,
    output logic [7:0]        INS_B3_O,
    output logic [1:0]        INS_LEN_O,
    output logic [ADDR_W-1:0] INS_PC_O,
    input  logic              BR_VALID_I,
    input  logic [1:0]        BR_TYPE_I,
    input  logic [ADDR_W-1:0] BR_ADDR_I,
    input  logic [ADDR_W-1:0] BR_RET_I,
    output logic              STK_ERR_O
);
    localparam int SW = $clog2(STACK_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);

    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [SW-1:0]     idx, idx_inc, idx_dec;
    logic [7:0]        fifo [FIFO_DEPTH];
    logic [FW-1:0]     wp, rp;
    logic [FW:0]       cnt;
    logic              run, epoch, req_q, req_ep;
    logic [1:0]        need, op_len;
    logic [ADDR_W-1:0] next_pc;
    logic              br, call, ret, push, pop, accept;
    logic [7:0]        head;

    assign br       = BR_VALID_I && BR_TYPE_I != 2'b11;
    assign call     = br && BR_TYPE_I == 2'b01;
    assign ret      = br && BR_TYPE_I == 2'b10;
    assign idx_inc  = idx + 1'b1;
    assign idx_dec  = idx - 1'b1;
    assign I_ADDR_O = stack[idx];
    // Outstanding reads reserve FIFO space, so a returning byte always has a slot.
    assign I_REQ_O  = run && ({1'b0, cnt} + (FW+2)'(req_q) < (FW+2)'(FIFO_DEPTH));
    assign push     = req_q && req_ep == epoch;
    assign head     = fifo[rp];
    assign accept   = INS_VALID_O && INS_READY_I;
    assign pop      = cnt != '0 && (!INS_VALID_O || INS_READY_I);
    assign op_len   = (head[7:6] == 2'b00 && head[2] && !head[0]) ? 2'd2 :
                      (head[7:6] == 2'b01 && !head[0]) ? 2'd3 : 2'd1;

    always_ff @(posedge CLK_I) begin
        if (!RST_I && !br && push) fifo[wp] <= I_DAT_I;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
            idx         <= '0;
            wp          <= '0;
            rp          <= '0;
            cnt         <= '0;
            run         <= 1'b0;
            epoch       <= 1'b0;
            req_q       <= 1'b0;
            req_ep      <= 1'b0;
            need        <= '0;
            next_pc     <= '0;
            INS_VALID_O <= 1'b0;
            INS_OP_O    <= '0;
            INS_B2_O    <= '0;
            INS_B3_O    <= '0;
            INS_LEN_O   <= '0;
            INS_PC_O    <= '0;
            STK_ERR_O   <= 1'b0;
        end else begin
            run       <= 1'b1;
            req_q     <= I_REQ_O;
            req_ep    <= epoch;
            STK_ERR_O <= (call && idx == SW'(STACK_DEPTH - 1)) || (ret && idx == '0);
            if (br) begin
                epoch       <= !epoch;
                wp          <= '0;
                rp          <= '0;
                cnt         <= '0;
                need        <= '0;
                INS_VALID_O <= 1'b0;
                if (ret) begin
                    idx     <= idx_dec;
                    next_pc <= stack[idx_dec];
                end else if (call) begin
                    stack[idx]     <= BR_RET_I;
                    stack[idx_inc] <= BR_ADDR_I;
                    idx            <= idx_inc;
                    next_pc        <= BR_ADDR_I;
                end else begin
                    stack[idx] <= BR_ADDR_I;
                    next_pc    <= BR_ADDR_I;
                end
            end else begin
                if (I_REQ_O) stack[idx] <= stack[idx] + 1'b1;
                if (push) wp <= wp + 1'b1;
                if (pop) rp <= rp + 1'b1;
                cnt <= cnt + (FW+1)'(push) - (FW+1)'(pop);
                if (pop && need == 2'd0) begin
                    INS_OP_O    <= head;
                    INS_B2_O    <= '0;
                    INS_B3_O    <= '0;
                    INS_LEN_O   <= op_len;
                    INS_PC_O    <= next_pc;
                    next_pc     <= next_pc + ADDR_W'(op_len);
                    need        <= op_len - 2'd1;
                    INS_VALID_O <= op_len == 2'd1;
                end else if (pop) begin
                    if (need == 2'd2 || INS_LEN_O == 2'd2) INS_B2_O <= head;
                    else INS_B3_O <= head;
                    need        <= need - 2'd1;
                    INS_VALID_O <= need == 2'd1;
                end else if (accept) begin
                    INS_VALID_O <= 1'b0;
                end
            end
        end
    end
endmodule
